// File: rtl/sparc_exu_zdet_seq_if.sv
// Bus bundle for the zero-detect sequencer: two requesters, the shared
// 32-bit OR-reduce unit and the result consumer.
//
// Handshake: a request transfers in a cycle where reqN_vld and reqN_rdy are
// both 1 at the rising clock edge; rdy never depends on anything but the
// sequencer state and the vld inputs. A result is offered while rsp_vld is 1,
// all rsp_* fields hold stable, and it is consumed at the edge where rsp_ack
// is 1; rsp_ack with rsp_vld low has no effect.
interface sparc_exu_zdet_seq_if;
  logic        req0_vld;
  logic        req1_vld;
  logic [63:0] req0_data;
  logic [63:0] req1_data;
  logic        req0_w64;
  logic        req1_w64;
  logic        req0_rdy;
  logic        req1_rdy;
  logic [31:0] or_in;
  logic        or_out;
  logic        rsp_vld;
  logic        rsp_id;
  logic        rsp_nz_lo;
  logic        rsp_nz;
  logic        rsp_ack;
  logic [3:0]  dbg_state;

  modport slave (
    input  req0_vld, req1_vld, req0_data, req1_data, req0_w64, req1_w64,
    input  or_out, rsp_ack,
    output req0_rdy, req1_rdy, or_in,
    output rsp_vld, rsp_id, rsp_nz_lo, rsp_nz, dbg_state
  );

  modport master (
    output req0_vld, req1_vld, req0_data, req1_data, req0_w64, req1_w64,
    output or_out, rsp_ack,
    input  req0_rdy, req1_rdy, or_in,
    input  rsp_vld, rsp_id, rsp_nz_lo, rsp_nz, dbg_state
  );
endinterface

// File: rtl/sparc_exu_zdet_seq.sv
// Two-requester nonzero detector. An accepted 64-bit operand is tested one
// 32-bit half per cycle through a shared external OR-reduce unit: the low half
// in LO, the high half in HI (64-bit requests only), then the result is held
// in RSP until acknowledged.
// Optional feature macro: ZDET_RR_ARB_EN selects round-robin arbitration
// between the requesters; without it requester 0 has fixed priority.
module sparc_exu_zdet_seq (
  input logic                 rclk,
  input logic                 arst_l,
  sparc_exu_zdet_seq_if.slave bus
);

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_LO   = 4'b0010,
    ST_HI   = 4'b0100,
    ST_RSP  = 4'b1000
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] data_q, data_d;
  logic        w64_q, w64_d;
  logic        id_q, id_d;
  logic        nz_lo_q, nz_lo_d;
  logic        nz_hi_q, nz_hi_d;

  logic        prio0;
  logic        gnt0, gnt1;
  logic        rdy0, rdy1;
  logic        accept;
  logic        acc_id;

  logic [31:0] or_in;
  logic        rsp_vld, rsp_id, rsp_nz_lo, rsp_nz;

  // prio0 high means requester 0 wins when both are valid
`ifdef ZDET_RR_ARB_EN
  logic rr_last_q, rr_last_d;

  assign prio0 = rr_last_q;

  // Last-grant pointer follows every acceptance
  always_comb begin
    rr_last_d = rr_last_q;
    if (accept) rr_last_d = acc_id;
  end

  // Pointer register; reset to 1 so requester 0 wins the first contention
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) rr_last_q <= 1'b1;
    else         rr_last_q <= rr_last_d;
  end
`else
  assign prio0 = 1'b1;
`endif

  // Arbitration: grants only in IDLE and never while reset is asserted
  always_comb begin
    gnt0   = bus.req0_vld & (~bus.req1_vld | prio0);
    gnt1   = bus.req1_vld & ~gnt0;
    rdy0   = (state_q == ST_IDLE) & arst_l & gnt0;
    rdy1   = (state_q == ST_IDLE) & arst_l & gnt1;
    accept = rdy0 | rdy1;
    acc_id = rdy1;
  end

  // State register
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_LO;
      ST_LO:   state_d = w64_q ? ST_HI : ST_RSP;
      ST_HI:   state_d = ST_RSP;
      ST_RSP:  if (bus.rsp_ack) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand capture and per-half OR results; nz_hi cleared on acceptance so a
  // 32-bit request cannot inherit a previous high-half result
  always_comb begin
    data_d  = data_q;
    w64_d   = w64_q;
    id_d    = id_q;
    nz_lo_d = nz_lo_q;
    nz_hi_d = nz_hi_q;
    if (accept) begin
      data_d  = acc_id ? bus.req1_data : bus.req0_data;
      w64_d   = acc_id ? bus.req1_w64  : bus.req0_w64;
      id_d    = acc_id;
      nz_lo_d = 1'b0;
      nz_hi_d = 1'b0;
    end
    if (state_q == ST_LO) nz_lo_d = bus.or_out;
    if (state_q == ST_HI) nz_hi_d = bus.or_out;
  end

  // Datapath registers
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      data_q  <= 64'h0;
      w64_q   <= 1'b0;
      id_q    <= 1'b0;
      nz_lo_q <= 1'b0;
      nz_hi_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      w64_q   <= w64_d;
      id_q    <= id_d;
      nz_lo_q <= nz_lo_d;
      nz_hi_q <= nz_hi_d;
    end
  end

  // Output decode from the current state
  always_comb begin
    or_in     = 32'h0;
    rsp_vld   = 1'b0;
    rsp_id    = 1'b0;
    rsp_nz_lo = 1'b0;
    rsp_nz    = 1'b0;
    case (state_q)
      ST_LO: or_in = data_q[31:0];
      ST_HI: or_in = data_q[63:32];
      ST_RSP: begin
        rsp_vld   = 1'b1;
        rsp_id    = id_q;
        rsp_nz_lo = nz_lo_q;
        rsp_nz    = nz_lo_q | (w64_q & nz_hi_q);
      end
      default: ;
    endcase
  end

  assign bus.req0_rdy  = rdy0;
  assign bus.req1_rdy  = rdy1;
  assign bus.or_in     = or_in;
  assign bus.rsp_vld   = rsp_vld;
  assign bus.rsp_id    = rsp_id;
  assign bus.rsp_nz_lo = rsp_nz_lo;
  assign bus.rsp_nz    = rsp_nz;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_sparc_exu_zdet_seq.sv
// Bench for sparc_exu_zdet_seq: directed scenarios plus randomized traffic,
// checked by a scoreboard fed from a behavioural model of arbitration,
// per-half timing and the nonzero results.
module tb_sparc_exu_zdet_seq;

  // ---------------- clock / reset ----------------
  logic rclk   = 1'b0;
  logic arst_l = 1'b0;
  always #5 rclk = ~rclk;

  sparc_exu_zdet_seq_if bus();

  // Shared OR-reduce unit
  assign bus.or_out = |bus.or_in;

  sparc_exu_zdet_seq dut (
    .rclk   (rclk),
    .arst_l (arst_l),
    .bus    (bus)
  );

  int cyc = 0;
  always @(posedge rclk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int         vectors    = 0;
  int         miscompares = 0;
  logic [2:0] exp_q[$];          // {id, nz_lo, nz}
  int         due_q[$];          // cycle in which rsp_vld must first appear
  logic       ids_seen[$];
  bit         record_ids = 0;

  bit          busy    = 0;
  bit          rr_last = 1;
  logic [63:0] cur_data;
  bit          cur_w64;
  int          acc_cyc = -10;
  int          last_acc_cyc = 0;
  int          last_ack_cyc = 0;
  int          last_hold = 0;
  int          rsp_run = 0;
  bit          rsp_seen = 0;
  bit          acc_flag[2];

  bit ack_low  = 0;
  bit ack_rand = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s: got timeout expected event (cycle %0d)", nm, cyc);
  endtask

  // ---------------- monitor / reference model ----------------
  always @(negedge rclk) begin
    logic [31:0] exp_or;
    logic [1:0]  exp_rdy;
    logic [63:0] d;
    bit          w;
    bit          win;
    bit          busy_clear;
    if (!arst_l) begin
      chk("reset outputs",
          64'({bus.req0_rdy, bus.req1_rdy, bus.rsp_vld, bus.rsp_id,
               bus.rsp_nz_lo, bus.rsp_nz, bus.or_in}), 64'h0);
      exp_q.delete();
      due_q.delete();
      busy     = 0;
      rr_last  = 1;
      rsp_seen = 0;
      rsp_run  = 0;
      acc_flag[0] = 0;
      acc_flag[1] = 0;
    end else begin
      busy_clear = 0;
      // shared-unit operand: low half one cycle after accept, high half next
      exp_or = 32'h0;
      if (busy && cyc == acc_cyc + 1)                 exp_or = cur_data[31:0];
      else if (busy && cur_w64 && cyc == acc_cyc + 2) exp_or = cur_data[63:32];
      chk("or_in", 64'(bus.or_in), 64'(exp_or));
      chk("state onehot", 64'($countones(bus.dbg_state)), 64'd1);

      // response side
      if (bus.rsp_vld) begin
        rsp_run++;
        if (exp_q.size() == 0) begin
          chk("unexpected rsp_vld", 64'(bus.rsp_vld), 64'd0);
        end else begin
          chk("rsp {id,nz_lo,nz}", 64'({bus.rsp_id, bus.rsp_nz_lo, bus.rsp_nz}), 64'(exp_q[0]));
          if (!rsp_seen) begin
            chk("rsp latency", 64'(cyc), 64'(due_q[0]));
            rsp_seen = 1;
          end
          if (bus.rsp_ack) begin
            if (record_ids) ids_seen.push_back(bus.rsp_id);
            void'(exp_q.pop_front());
            void'(due_q.pop_front());
            last_hold    = rsp_run;
            last_ack_cyc = cyc;
            rsp_run      = 0;
            rsp_seen     = 0;
            busy_clear   = 1;
          end
        end
      end else begin
        chk("rsp fields idle", 64'({bus.rsp_id, bus.rsp_nz_lo, bus.rsp_nz}), 64'h0);
        if (exp_q.size() > 0 && cyc >= due_q[0]) begin
          fail_now("rsp_vld missing");
          void'(exp_q.pop_front());
          void'(due_q.pop_front());
          busy_clear = 1;
        end
      end

      // request side: who should be granted this cycle
      exp_rdy = 2'b00;
      win     = 0;
      if (!busy) begin
        if (bus.req0_vld && bus.req1_vld) begin
`ifdef ZDET_RR_ARB_EN
          win = ~rr_last;
`else
          win = 0;
`endif
          exp_rdy = win ? 2'b10 : 2'b01;
        end else if (bus.req0_vld) begin
          win = 0; exp_rdy = 2'b01;
        end else if (bus.req1_vld) begin
          win = 1; exp_rdy = 2'b10;
        end
      end
      chk("rdy {1,0}", 64'({bus.req1_rdy, bus.req0_rdy}), 64'(exp_rdy));
      if (exp_rdy != 2'b00) begin
        d = win ? bus.req1_data : bus.req0_data;
        w = win ? bus.req1_w64  : bus.req0_w64;
        exp_q.push_back({win, |d[31:0], w ? |d : |d[31:0]});
        due_q.push_back(cyc + (w ? 3 : 2));
        busy          = 1;
        cur_data      = d;
        cur_w64       = w;
        acc_cyc       = cyc;
        last_acc_cyc  = cyc;
        rr_last       = win;
        acc_flag[win] = 1;
      end
      if (busy_clear) busy = 0;
    end
  end

  // consumer
  always @(posedge rclk) begin
    #1;
    if (ack_low)       bus.rsp_ack = 1'b0;
    else if (ack_rand) bus.rsp_ack = 1'($urandom_range(0, 1));
    else               bus.rsp_ack = 1'b1;
  end

  // ---------------- driver tasks ----------------
  task automatic send(input int id, input logic [63:0] d, input logic w);
    int n;
    n = 0;
    #1;
    if (id == 0) begin
      bus.req0_data = d; bus.req0_w64 = w; bus.req0_vld = 1'b1;
    end else begin
      bus.req1_data = d; bus.req1_w64 = w; bus.req1_vld = 1'b1;
    end
    do begin
      @(posedge rclk);
      n++;
    end while (!acc_flag[id] && n < 300);
    if (acc_flag[id]) acc_flag[id] = 0;
    else fail_now("request accept");
    #1;
    if (id == 0) bus.req0_vld = 1'b0;
    else         bus.req1_vld = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 200) begin
      @(posedge rclk);
      n++;
    end
    if (n >= 200) fail_now("drain");
    #1;
  endtask

  function automatic logic [63:0] rand_data();
    case ($urandom_range(0, 3))
      0:       return 64'h0;
      1:       return {32'h0, 32'($urandom)};
      2:       return {32'($urandom), 32'h0};
      default: return {32'($urandom), 32'($urandom)};
    endcase
  endfunction

  task automatic stream(input int id, input int count);
    for (int i = 0; i < count; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge rclk);
      send(id, rand_data(), 1'($urandom_range(0, 1)));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic exp_ids[4];
    bus.req0_vld = 0; bus.req1_vld = 0;
    bus.req0_data = 0; bus.req1_data = 0;
    bus.req0_w64 = 0; bus.req1_w64 = 0;
    bus.rsp_ack = 0;

    repeat (3) @(posedge rclk);
    #2 arst_l = 1'b1;
    @(posedge rclk);

    // all-zero 32-bit operand
    send(0, 64'h0, 1'b0);
    wait_idle();

    // high-half-only operand as 64-bit, then the same as 32-bit
    send(1, 64'h0000_0001_0000_0000, 1'b1);
    wait_idle();
    send(1, 64'h0000_0001_0000_0000, 1'b0);
    wait_idle();

    // contention with immediate ack
    ids_seen.delete();
    record_ids = 1;
    fork
      for (int i = 0; i < 4; i++) send(0, rand_data(), 1'($urandom_range(0, 1)));
      for (int i = 0; i < 4; i++) send(1, rand_data(), 1'($urandom_range(0, 1)));
    join
    wait_idle();
    record_ids = 0;
`ifdef ZDET_RR_ARB_EN
    exp_ids = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_ids = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    chk("contention count", 64'(ids_seen.size()), 64'd8);
    for (int i = 0; i < 4; i++)
      if (i < ids_seen.size()) chk("contention id", 64'(ids_seen[i]), 64'(exp_ids[i]));

    // ack held low for five cycles, second request waiting on req1
    ack_low = 1;
    fork
      send(0, 64'h8000_0000_0000_0000, 1'b1);
      begin
        int n;
        n = 0;
        while (rsp_run < 1 && n < 100) begin @(posedge rclk); n++; end
        send(1, 64'h0000_0000_0000_00FF, 1'b0);
      end
      begin
        int n;
        n = 0;
        while (rsp_run < 5 && n < 100) begin @(posedge rclk); n++; end
        if (n >= 100) fail_now("rsp hold");
        ack_low = 0;
      end
    join
    chk("accept after ack", 64'(last_acc_cyc), 64'(last_ack_cyc + 1));
    wait_idle();
    chk("hold cycles incl ack", 64'(last_hold), 64'd1);

    // reset pulse in HI
    ack_low = 1;
    send(0, 64'hFFFF_0000_0000_0000, 1'b1);
    @(posedge rclk);
    #2 arst_l = 1'b0;
    #1;
    chk("async reset outputs",
        64'({bus.req0_rdy, bus.req1_rdy, bus.rsp_vld, bus.rsp_id,
             bus.rsp_nz_lo, bus.rsp_nz, bus.or_in}), 64'h0);
    @(posedge rclk);
    #3 arst_l = 1'b1;
    ack_low = 0;
    repeat (5) @(posedge rclk);
    send(1, 64'h0000_0000_0000_0001, 1'b0);
    wait_idle();

    // randomized traffic with random ack
    ack_rand = 1;
    fork
      stream(0, 15);
      stream(1, 15);
    join
    ack_rand = 0;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // The sequence above already follows the held-ack case with a second
  // accepted request; its hold count is checked there against the final ack.
  initial begin
    #2000000;
    $display("FAIL global timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/sparc_exu_zdet_seq.md
SPARC_EXU_ZDET_SEQ -- requirements
Module: sparc_exu_zdet_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all other ports are listed below.
REQ-002 rclk  in  1  clock; all state updates on the rising edge.
REQ-003 arst_l  in  1  reset; asynchronous assert, active-low.
REQ-004 req0_vld / req1_vld  in  1  requester 0/1 has an operand.
REQ-005 req0_data / req1_data  in  64  operand to test for nonzero.
REQ-006 req0_w64 / req1_w64  in  1  operand width: 1 tests all 64 bits, 0 tests bits [31:0] only.
REQ-007 req0_rdy / req1_rdy  out  1  grant; a request is accepted in a cycle where vld and rdy are both 1.
REQ-008 or_in  out  32  operand half driven to the shared external 32-bit OR-reduce unit.
REQ-009 or_out  in  1  combinational OR of or_in, returned from the shared unit in the same cycle.
REQ-010 rsp_vld  out  1  result valid.
REQ-011 rsp_id  out  1  requester that owns the result.
REQ-012 rsp_nz_lo  out  1  bits [31:0] of the operand are nonzero.
REQ-013 rsp_nz  out  1  the whole tested operand is nonzero.
REQ-014 rsp_ack  in  1  consumer accepts the result.

Function
REQ-015 The FSM SHALL have the states IDLE, LO, HI and RSP and SHALL encode them one-hot.
REQ-016 The rdy outputs SHALL be asserted only in IDLE, and at most one of them SHALL be 1 in any cycle.
REQ-017 In IDLE with exactly one vld high, the rdy of that requester SHALL be 1.
REQ-018 With both vld high in IDLE, the winner SHALL be decided per REQ-031/REQ-032.
REQ-019 On acceptance in cycle T, the block SHALL register the data, w64 and id, and the state SHALL be LO in T+1.
REQ-020 In LO, or_in SHALL be data[31:0], and or_out SHALL be registered into nz_lo at the end of the cycle.
REQ-021 LO SHALL go to HI if w64=1, else to RSP.
REQ-022 In HI, or_in SHALL be data[63:32], and or_out SHALL be registered into nz_hi at the end of the cycle; HI SHALL then go to RSP.
REQ-023 In IDLE and RSP, or_in SHALL be 32'h0.
REQ-024 Latency from the acceptance cycle T to rsp_vld SHALL be T+2 for w64=0 and T+3 for w64=1.
REQ-025 In RSP, rsp_vld=1, rsp_nz_lo=nz_lo, and rsp_nz = nz_lo | (w64 & nz_hi).
REQ-026 All rsp_* outputs SHALL hold stable until rsp_ack.
REQ-027 rsp_ack sampled high in RSP SHALL move the state to IDLE; the earliest next acceptance is the cycle after the ack.
REQ-028 rsp_ack outside RSP SHALL be ignored.
REQ-029 Outside RSP, rsp_vld, rsp_id, rsp_nz_lo and rsp_nz SHALL be 0.
REQ-030 nz_hi SHALL be cleared on acceptance so that a 32-bit request never sees a stale high-half result.

Configuration
REQ-031 With ZDET_RR_ARB_EN defined, the block SHALL use round-robin arbitration:
- a last-grant pointer updates on every acceptance;
- when both requesters are valid, the grant goes to the requester that was not last granted;
- the pointer resets to 1, so requester 0 wins the first contention.
REQ-032 Without ZDET_RR_ARB_EN, arbitration SHALL be fixed priority with requester 0 always winning, and no pointer state shall exist.

Reset
REQ-033 arst_l low SHALL asynchronously force:
- state to IDLE;
- all rdy and rsp_* outputs to 0;
- or_in to 0;
- nz_lo, nz_hi and the captured operand to 0;
- the RR pointer to 1.
REQ-034 Reset asserted during LO, HI or RSP SHALL discard the in-flight operation, and no rsp_vld shall follow for it.
REQ-035 After arst_l deasserts, the first rising edge SHALL sample requests normally from IDLE.

Verification
REQ-036 Bench SHALL cover: req0 data=64'h0, w64=0 -> rsp_vld at T+2, rsp_id=0, rsp_nz_lo=0, rsp_nz=0; or_in=0 in LO.
REQ-037 Bench SHALL cover: req1 data=64'h0000_0001_0000_0000 with w64=1, then w64=0 -> first: T+3, nz_lo=0, nz=1; second: T+2, nz=0 (stale nz_hi not used).
REQ-038 Bench SHALL cover: both vld held high for 4 back-to-back requests with immediate ack -> with ZDET_RR_ARB_EN the id sequence is 0,1,0,1; without it, 0,0,0,0.
REQ-039 Bench SHALL cover: rsp_ack held low 5 cycles in RSP, data=64'h8000_0000_0000_0000, w64=1 -> rsp_vld, rsp_nz=1 and rsp_nz_lo=0 stable for all 5 cycles, rdy=0, next accept the cycle after ack.
REQ-040 Bench SHALL cover: arst_l pulsed low during HI -> all outputs 0 immediately, no rsp_vld afterwards, new request accepted in IDLE with correct result.
